// File: rtl/writeback_queue.sv
// Writeback queue: merges ALU and load results into the integer register file write port.
// Latency: accepted at edge N into an empty queue, presented after edge N+1, committed at N+2.
// Backpressure: ready depends on occupancy only; the ALU needs two free slots while a load is offered.
module writeback_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            mem_valid,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic            mem_ready,
    output logic            reg_write,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_data,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic            rs1_pending,
    output logic            rs2_pending
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    wb_entry_t        slots [DEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [CW-1:0]    count;
    logic [CW-1:0]    free;
    logic             mem_push;
    logic             alu_push;
    logic             pop;
    logic [AW-1:0]    alu_slot;
    logic [DEPTH-1:0] slot_vld;

    assign free = CW'(DEPTH) - count;

    // Readiness ignores a same-cycle pop so it never depends on the drain path.
    assign mem_ready = !flush && (free >= CW'(1));
    assign alu_ready = !flush && (mem_valid ? (free >= CW'(2)) : (free >= CW'(1)));

    // x0 writes complete the handshake but never occupy a slot.
    assign mem_push = mem_valid && mem_ready && (mem_rd != 5'd0);
    assign alu_push = alu_valid && alu_ready && (alu_rd != 5'd0);
    assign pop      = (count != '0);

    // The load is older in program order, so it takes the tail slot first.
    assign alu_slot = tail + AW'(mem_push);

    always_ff @(posedge clk) begin
        if (mem_push) begin
            slots[tail] <= '{rd: mem_rd, data: mem_data};
        end
        if (alu_push) begin
            slots[alu_slot] <= '{rd: alu_rd, data: alu_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            reg_write <= 1'b0;
            rd_addr   <= '0;
            rd_data   <= '0;
        end else if (flush) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            reg_write <= 1'b0;
        end else begin
            reg_write <= pop;
            if (pop) begin
                {rd_addr, rd_data} <= slots[head];
                head               <= head + AW'(1);
            end
            tail  <= tail + AW'(mem_push) + AW'(alu_push);
            count <= count + CW'(mem_push) + CW'(alu_push) - CW'(pop);
        end
    end

    // A slot is live when its distance from head is below the occupancy.
    always_comb begin
        slot_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_vld[i] = (CW'(AW'(i) - head) < count) || (count == CW'(DEPTH));
        end
    end

    always_comb begin
        rs1_pending = 1'b0;
        rs2_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_vld[i] && (slots[i].rd == rs1_addr)) rs1_pending = 1'b1;
            if (slot_vld[i] && (slots[i].rd == rs2_addr)) rs2_pending = 1'b1;
        end
        if (reg_write && (rd_addr == rs1_addr)) rs1_pending = 1'b1;
        if (reg_write && (rd_addr == rs2_addr)) rs2_pending = 1'b1;
        if (rs1_addr == 5'd0) rs1_pending = 1'b0;
        if (rs2_addr == 5'd0) rs2_pending = 1'b0;
    end

endmodule
